// File: rtl/sram_ctrl_pkg.sv
// Shared state type, strobe bundle and timing defaults for the asynchronous SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned WAIT_W      = 4;
    localparam int unsigned DEF_ADDR_W  = 20;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_RD_WAIT = 1;
    localparam int unsigned DEF_WR_WAIT = 1;
    localparam int unsigned DEF_CBITS   = 26;

    typedef logic [WAIT_W-1:0] wait_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_e;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic dq_oe;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};

    // Pad strobes for the cycle spent in a given state; oe_n and dq_oe are never both active.
    function automatic strobe_t strobes_for(state_e st);
        strobe_t s;
        s = STROBE_IDLE;
        case (st)
            ST_READ: begin
                s.ce_n = 1'b0;
                s.oe_n = 1'b0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                s.ce_n  = 1'b0;
                s.dq_oe = 1'b1;
            end
            ST_WR_PULSE: begin
                s.ce_n  = 1'b0;
                s.we_n  = 1'b0;
                s.dq_oe = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sram_heartbeat.sv
// Free-running CBITS-bit counter whose MSB drives a board-alive LED.
module sram_heartbeat
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned CBITS = DEF_CBITS
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_led
);

    logic [CBITS-1:0] count_q;
    logic [CBITS-1:0] count_d;

    always_comb begin
        count_d = count_q + CBITS'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_led = count_q[CBITS-1];

endmodule

// File: rtl/sram_ctrl.sv
// Single-word host-to-asynchronous-SRAM controller with configurable read/write wait states.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RD_WAIT = DEF_RD_WAIT,
    parameter int unsigned WR_WAIT = DEF_WR_WAIT,
    parameter int unsigned CBITS   = DEF_CBITS
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ready,
    output logic              o_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_dq_out,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq_in,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_led
);

    localparam wait_t RD_WAIT_V = wait_t'(RD_WAIT);
    localparam wait_t WR_WAIT_V = wait_t'(WR_WAIT);
    localparam wait_t WAIT_ONE  = wait_t'(1);

    state_e              state_q,  state_d;
    wait_t               wait_q,   wait_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    logic                rvalid_q, rvalid_d;
    strobe_t             strobe_q, strobe_d;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    if (i_we) begin
                        state_d = ST_WR_SETUP;
                        wait_d  = '0;
                    end else begin
                        state_d = ST_READ;
                        wait_d  = RD_WAIT_V;
                    end
                end
            end
            ST_READ: begin
                if (wait_q == '0) begin
                    rdata_d  = i_sram_dq_in;
                    rvalid_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                wait_d  = WR_WAIT_V;
            end
            ST_WR_PULSE: begin
                if (wait_q == '0) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Strobes are registered from the next state so the pads never see host inputs combinationally.
        strobe_d = strobes_for(state_d);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            strobe_q <= STROBE_IDLE;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            strobe_q <= strobe_d;
        end
    end

    assign o_ready       = (state_q == ST_IDLE) && !i_reset;
    assign o_rvalid      = rvalid_q;
    assign o_rdata       = rdata_q;
    assign o_sram_addr   = addr_q;
    assign o_sram_dq_out = wdata_q;
    assign o_sram_dq_oe  = strobe_q.dq_oe;
    assign o_sram_ce_n   = strobe_q.ce_n;
    assign o_sram_oe_n   = strobe_q.oe_n;
    assign o_sram_we_n   = strobe_q.we_n;

    sram_heartbeat #(
        .CBITS(CBITS)
    ) u_heartbeat (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .o_led  (o_led)
    );

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three parameterisations, behavioural SRAM on split DQ, cycle-level reference model.
module tb_sram_ctrl;

    localparam int NI = 3;

    function automatic int aw_of(int i); return (i == 2) ? 18 : 20; endfunction
    function automatic int dw_of(int i); return (i == 2) ? 16 : 8;  endfunction
    function automatic int rw_of(int i); return (i == 0) ? 1 : (i == 1) ? 0 : 3; endfunction
    function automatic int ww_of(int i); return (i == 0) ? 1 : (i == 1) ? 0 : 3; endfunction
    function automatic logic [19:0] amask(int i); return 20'((64'd1 << aw_of(i)) - 64'd1); endfunction
    function automatic logic [15:0] dmask(int i); return 16'((64'd1 << dw_of(i)) - 64'd1); endfunction
    function automatic int key_of(int i, logic [19:0] a); return i * 32'h0010_0000 + int'(a); endfunction
    function automatic logic [15:0] power_up(int i, logic [19:0] a); return 16'(a ^ 20'h0005A) & dmask(i); endfunction

    logic clk;
    logic rst;
    logic        req   [NI];
    logic        we    [NI];
    logic [19:0] addr  [NI];
    logic [15:0] wdata [NI];
    logic [15:0] dqi   [NI];
    logic        ce_n [NI], oe_n [NI], we_n [NI], dq_oe [NI], ready [NI], rvalid [NI], led [NI];
    logic [19:0] sa   [NI];
    logic [15:0] dqo  [NI];
    logic [15:0] rdat [NI];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int AW = aw_of(g);
        localparam int DW = dw_of(g);
        logic [AW-1:0] sa_l;
        logic [DW-1:0] dqo_l, rd_l;
        logic ce_l, oe_l, we_l, dqoe_l, rdy_l, rv_l, led_l;

        sram_ctrl #(
            .ADDR_W (AW),
            .DATA_W (DW),
            .RD_WAIT(rw_of(g)),
            .WR_WAIT(ww_of(g)),
            .CBITS  (4)
        ) u_dut (
            .i_clk        (clk),
            .i_reset      (rst),
            .i_req        (req[g]),
            .i_we         (we[g]),
            .i_addr       (addr[g][AW-1:0]),
            .i_wdata      (wdata[g][DW-1:0]),
            .o_ready      (rdy_l),
            .o_rvalid     (rv_l),
            .o_rdata      (rd_l),
            .o_sram_addr  (sa_l),
            .o_sram_dq_out(dqo_l),
            .o_sram_dq_oe (dqoe_l),
            .i_sram_dq_in (dqi[g][DW-1:0]),
            .o_sram_ce_n  (ce_l),
            .o_sram_oe_n  (oe_l),
            .o_sram_we_n  (we_l),
            .o_led        (led_l)
        );

        assign ce_n[g]   = ce_l;
        assign oe_n[g]   = oe_l;
        assign we_n[g]   = we_l;
        assign dq_oe[g]  = dqoe_l;
        assign ready[g]  = rdy_l;
        assign rvalid[g] = rv_l;
        assign led[g]    = led_l;
        assign sa[g]     = 20'(sa_l);
        assign dqo[g]    = 16'(dqo_l);
        assign rdat[g]   = 16'(rd_l);
    end

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, i, cyc, act, exp);
        end
    endtask

    // Behavioural SRAM: writes land while WE# is low with DQ driven, reads drive DQ under CE#/OE#.
    logic [15:0] smem [int];
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!ce_n[i] && !we_n[i] && dq_oe[i]) smem[key_of(i, sa[i])] = dqo[i];
            if (!ce_n[i] && !oe_n[i])
                dqi[i] = smem.exists(key_of(i, sa[i])) ? smem[key_of(i, sa[i])] : power_up(i, sa[i]);
            else
                dqi[i] = 16'h0F0F & dmask(i);
        end
    end

    // Reference model: tracks each accepted transaction by its cycle offset from the accept edge.
    logic [15:0] ref_mem [int];
    bit          busy   [NI];
    bit          m_wr   [NI];
    int          ph     [NI];
    logic [19:0] last_a [NI];
    logic [15:0] last_d [NI];
    logic [15:0] exp_rd [NI];
    bit          exp_rv [NI];
    longint unsigned hb [NI];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                busy[i] = 0; exp_rv[i] = 0; exp_rd[i] = '0;
                last_a[i] = '0; last_d[i] = '0; hb[i] = 0; ph[i] = 0;
            end else begin
                hb[i]++;
                exp_rv[i] = 0;
                if (!busy[i] && req[i]) begin
                    busy[i] = 1; ph[i] = 0; m_wr[i] = we[i];
                    last_a[i] = addr[i] & amask(i);
                    last_d[i] = wdata[i] & dmask(i);
                    if (we[i]) ref_mem[key_of(i, last_a[i])] = last_d[i];
                end
                if (busy[i]) begin
                    ph[i]++;
                    if (ph[i] == (m_wr[i] ? ww_of(i) + 4 : rw_of(i) + 2)) begin
                        busy[i] = 0;
                        if (!m_wr[i]) begin
                            exp_rv[i] = 1;
                            exp_rd[i] = ref_mem.exists(key_of(i, last_a[i])) ?
                                        ref_mem[key_of(i, last_a[i])] : power_up(i, last_a[i]);
                        end
                    end
                end
            end
        end
    end

    logic e_ce, e_oe, e_we, e_dq;
    always begin
        @(posedge clk);
        #2;
        for (int i = 0; i < NI; i++) begin
            e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_dq = 1'b0;
            if (busy[i]) begin
                e_ce = 1'b0;
                if (!m_wr[i]) e_oe = 1'b0;
                else begin
                    e_dq = 1'b1;
                    if (ph[i] >= 2 && ph[i] <= ww_of(i) + 2) e_we = 1'b0;
                end
            end
            chk("ce_n",   i, 32'(ce_n[i]),   32'(e_ce));
            chk("oe_n",   i, 32'(oe_n[i]),   32'(e_oe));
            chk("we_n",   i, 32'(we_n[i]),   32'(e_we));
            chk("dq_oe",  i, 32'(dq_oe[i]),  32'(e_dq));
            chk("ready",  i, 32'(ready[i]),  32'(!busy[i] && !rst));
            chk("rvalid", i, 32'(rvalid[i]), 32'(exp_rv[i]));
            chk("rdata",  i, 32'(rdat[i]),   32'(exp_rd[i]));
            chk("addr",   i, 32'(sa[i]),     32'(last_a[i]));
            chk("dq_out", i, 32'(dqo[i]),    32'(last_d[i]));
            chk("led",    i, 32'(led[i]),    32'(hb[i][3]));
        end
    end

    // Issue one request when idle; lat counts cycles from accept to rvalid (read) or ready (write).
    task automatic do_req(int i, bit w, logic [19:0] a, logic [15:0] d,
                          output int lat, output int welow, output logic [15:0] rd);
        int n;
        n = 0;
        while (!ready[i] && n < 100) begin @(negedge clk); n++; end
        chk("idle_wait", i, 32'(ready[i]), 32'd1);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        @(posedge clk);
        @(negedge clk);
        req[i] = 1'b0;
        lat = 1; welow = 0;
        while (!(w ? ready[i] : rvalid[i]) && lat < 100) begin
            if (!we_n[i]) welow++;
            @(negedge clk);
            lat++;
        end
        rd = rdat[i];
    endtask

    int lat, wl, t_prev;
    logic [15:0] rd;
    logic [15:0] b2b_exp [3];

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", 0, 32'(ready[0]), 32'd0);
        chk("rst_ce",    0, 32'(ce_n[0]),  32'd1);
        rst = 1'b0;
        #1;
        chk("rel_ready", 0, 32'(ready[0]), 32'd1);
        @(negedge clk);

        do_req(0, 1'b1, 20'h12345, 16'h00A5, lat, wl, rd);
        chk("wr_lat",  0, 32'(lat), 32'd5);
        chk("we_low",  0, 32'(wl),  32'd2);
        do_req(0, 1'b0, 20'h12345, 16'h0000, lat, wl, rd);
        chk("rd_lat",  0, 32'(lat), 32'd3);
        chk("rd_data", 0, 32'(rd),  32'h00A5);

        do_req(1, 1'b1, 20'hABCDE, 16'h003C, lat, wl, rd);
        chk("wr_lat",  1, 32'(lat), 32'd4);
        chk("we_low",  1, 32'(wl),  32'd1);
        do_req(1, 1'b0, 20'hABCDE, 16'h0000, lat, wl, rd);
        chk("rd_lat",  1, 32'(lat), 32'd2);
        chk("rd_data", 1, 32'(rd),  32'h003C);

        do_req(2, 1'b1, 20'h3FFFF, 16'hBEEF, lat, wl, rd);
        chk("wr_lat",  2, 32'(lat), 32'd7);
        chk("we_low",  2, 32'(wl),  32'd4);
        do_req(2, 1'b0, 20'h3FFFF, 16'h0000, lat, wl, rd);
        chk("rd_lat",  2, 32'(lat), 32'd5);
        chk("rd_data", 2, 32'(rd),  32'hBEEF);

        b2b_exp[0] = 16'h005A; b2b_exp[1] = 16'h005B; b2b_exp[2] = 16'h0058;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            do_req(0, 1'b0, 20'(k), 16'h0000, lat, wl, rd);
            chk("b2b_data", 0, 32'(rd), 32'(b2b_exp[k]));
            if (k > 0) chk("b2b_gap", 0, 32'(cyc - t_prev), 32'd3);
            t_prev = cyc;
        end

        // Request held high through READ with different fields must be ignored.
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 20'h00033; wdata[0] = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        we[0] = 1'b1; addr[0] = 20'h00777; wdata[0] = 16'h0011;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        chk("ign_rvalid", 0, 32'(rvalid[0]), 32'd1);
        chk("ign_rdata",  0, 32'(rdat[0]),   32'h0069);
        @(negedge clk);
        chk("ign_ce",     0, 32'(ce_n[0]),   32'd1);
        chk("ign_ready",  0, 32'(ready[0]),  32'd1);
        do_req(0, 1'b0, 20'h00777, 16'h0000, lat, wl, rd);
        chk("ign_nowr",   0, 32'(rd),        32'h002D);

        // Reset asserted in the first WE# low cycle of a write.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 20'h00055; wdata[0] = 16'h0099;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        chk("pre_rst_we", 0, 32'(we_n[0]), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_we",    0, 32'(we_n[0]),  32'd1);
        chk("rst_ce2",   0, 32'(ce_n[0]),  32'd1);
        chk("rst_dqoe",  0, 32'(dq_oe[0]), 32'd0);
        chk("rst_rdy2",  0, 32'(ready[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_rdy2",  0, 32'(ready[0]), 32'd1);
        do_req(0, 1'b0, 20'h12345, 16'h0000, lat, wl, rd);
        chk("post_rst_rd", 0, 32'(rd), 32'h00A5);

        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Parametrised controller for the external asynchronous SRAM. Generalises the 1Mx8 device to any ADDR_W x DATA_W part.
- Converts single-word host read/write requests, using a ready/valid handshake, into correctly sequenced CE#/OE#/WE# strobes with configurable wait states.
- Keeps the CBITS heartbeat LED counter as a board-alive indicator.
- Sits between the host logic and the top-level tristate pads. The top level performs the tristate; this block exposes split DQ in/out/oe.

Parameters:
- ADDR_W, 20, SRAM address width in bits.
- DATA_W, 8, SRAM data width in bits.
- RD_WAIT, 1, extra read access cycles, 0..15.
- WR_WAIT, 1, extra WE# low cycles, 0..15.
- CBITS, 26, heartbeat counter width (benches use 4).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous active-high reset
- i_req  in  1  host request, sampled only when o_ready=1
- i_we  in  1  1=write, 0=read, qualified by i_req
- i_addr  in  ADDR_W  request address
- i_wdata  in  DATA_W  write data
- o_ready  out  1  controller idle; a request is accepted this cycle
- o_rvalid  out  1  one-cycle pulse: o_rdata is valid
- o_rdata  out  DATA_W  last read data, held until the next read completes
- o_sram_addr  out  ADDR_W  SRAM address bus
- o_sram_dq_out  out  DATA_W  data to pads
- o_sram_dq_oe  out  1  pad output enable
- i_sram_dq_in  in  DATA_W  data from pads
- o_sram_ce_n  out  1  chip enable, active low
- o_sram_oe_n  out  1  output enable, active low
- o_sram_we_n  out  1  write enable, active low
- o_led  out  1  heartbeat, equal to counter MSB

Behaviour:
- Reset (asynchronous, any state, including mid-access):
  - FSM goes to IDLE.
  - ce_n, oe_n and we_n are 1. dq_oe is 0.
  - o_rvalid, o_rdata, o_sram_addr, o_sram_dq_out and the heartbeat counter are 0.
  - o_ready is 0 while i_reset=1 and is 1 in the first cycle after release.
  - An aborted write leaves SRAM contents undefined at that address only.
- All SRAM outputs are registered: no combinational path from host inputs to pads.
- Accept rule:
  - A request is accepted when i_req=1 and o_ready=1 at a rising edge.
  - Requests while o_ready=0 are ignored, not queued.
  - i_addr, i_wdata and i_we are latched on accept.
- FSM states: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD. A 4-bit wait counter is loaded on state entry.
- Read, with accept edge at cycle 0:
  - Cycles 1..1+RD_WAIT are READ: ce_n=0, oe_n=0, we_n=1, dq_oe=0, address driven.
  - At the edge ending the last READ cycle, o_rdata is loaded from i_sram_dq_in.
  - Cycle 2+RD_WAIT is IDLE with o_rvalid=1 and o_ready=1.
  - Read latency from accept to o_rvalid is RD_WAIT+2 cycles (3 at default).
- Write, with accept edge at cycle 0:
  - WR_SETUP is 1 cycle: ce_n=0, we_n=1, oe_n=1, dq_oe=1, addr and data driven.
  - WR_PULSE is WR_WAIT+1 cycles with we_n=0.
  - WR_HOLD is 1 cycle with we_n=1; addr, data and dq_oe are still held.
  - IDLE follows: o_ready=1 at cycle WR_WAIT+4 (5 at default). No o_rvalid for writes.
- oe_n and dq_oe are never both active. we_n=0 only in WR_PULSE.
- In IDLE:
  - ce_n=1, oe_n=1, we_n=1, dq_oe=0.
  - Address and data registers hold their last values.
- Back-to-back: the cycle with o_rvalid=1 may accept a new request. Sustained read throughput is one word per RD_WAIT+2 cycles.
- RD_WAIT=0 and WR_WAIT=0 are legal, giving minimum 2-cycle reads and 4-cycle writes.
- Heartbeat:
  - The CBITS-bit free-running counter increments every cycle and wraps to 0 after all-ones.
  - o_led = counter[CBITS-1].

Decomposition:
- Include file sram_defs.vh holds:
  - state encodings (3-bit localparams ST_IDLE..ST_WR_HOLD);
  - default timing constants;
  - the wait-counter width (4).
- One natural sub-module: sram_heartbeat (CBITS counter to o_led), reusable by other boards.
- The FSM and datapath stay in sram_ctrl.

Test Plan:
- Reset: assert i_reset mid-WR_PULSE at default params -> same-cycle we_n=1, ce_n=1, dq_oe=0, o_ready=0; o_ready=1 on the first cycle after release.
- Single write then read:
  - stimulus: write addr 0x12345 data 0xA5, then read 0x12345, using a behavioural SRAM model on the split DQ;
  - write: we_n low exactly 2 cycles, o_ready back 5 cycles after accept;
  - read: o_rvalid 3 cycles after accept, o_rdata=0xA5.
- Wait-state sweep: RD_WAIT=0 and 3, WR_WAIT=0 and 3 -> read latency 2 and 5, write occupancy 4 and 7 cycles; data correct in every case.
- Back-to-back reads: addrs 0,1,2 each issued on the o_rvalid cycle, model holding data = addr ^ 0x5A -> o_rvalid pulses every 3 cycles, rdata 0x5A, 0x5B, 0x58.
- Ignored request: pulse i_req during READ -> no extra access; ce_n returns to 1 in the next IDLE.
- Heartbeat and width: CBITS=4, DATA_W=16, ADDR_W=18 -> o_led toggles every 8 cycles; a 16-bit write/read of 0xBEEF round-trips at addr 0x3FFFF.
